// File: rtl/hpf_diff_iir_pkg.sv
// rtl/hpf_diff_iir_pkg.sv - shared FSM type and arithmetic helpers for the differential HPF
package hpf_diff_iir_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Clamp to a w-bit signed range; bit 64 of the result flags that clamping happened.
  function automatic logic [64:0] sat_w(input logic signed [63:0] value, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return {1'b1, hi};
    if (value < lo) return {1'b1, lo};
    return {1'b0, value};
  endfunction

  function automatic int clamp_shift(input int ts, input int smax);
    return (ts > smax) ? smax : ts;
  endfunction

endpackage

// File: rtl/hpf_diff_iir_leg_dp.sv
// rtl/hpf_diff_iir_leg_dp.sv - combinational single-leg state update, state held as y*2^S
module hpf_leg_dp
  import hpf_diff_iir_pkg::*;
#(
  parameter int W     = 16,
  parameter int ACC_W = 28,
  parameter int SW    = 4
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [W-1:0]     i_x,
  input  logic signed [W-1:0]     i_x_prev,
  input  logic signed [W-1:0]     i_bias,
  input  logic [SW-1:0]           i_shift,
  input  logic                    i_prime,
  input  logic                    i_bypass,
  output logic signed [ACC_W-1:0] o_acc,
  output logic signed [W-1:0]     o_y,
  output logic                    o_ovf
);

  logic signed [W:0]       w_dx;
  logic signed [ACC_W-1:0] w_dx_acc;
  logic signed [ACC_W-1:0] w_bias_acc;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_y_full;
  logic signed [ACC_W-1:0] w_y_clamp_acc;
  logic signed [63:0]      w_y64;
  logic [64:0]             w_sat;
  logic                    w_sat_unused;

  assign w_dx          = {i_x[W-1], i_x} - {i_x_prev[W-1], i_x_prev};
  assign w_dx_acc      = {{(ACC_W-W-1){w_dx[W]}}, w_dx};
  assign w_bias_acc    = {{(ACC_W-W){i_bias[W-1]}}, i_bias};
  assign w_sum         = i_acc - (i_acc >>> i_shift) + w_bias_acc + (w_dx_acc <<< i_shift);
  assign w_y_full      = w_sum >>> i_shift;
  assign w_y64         = {{(64-ACC_W){w_y_full[ACC_W-1]}}, w_y_full};
  assign w_sat         = sat_w(w_y64, W);
  assign w_sat_unused  = ^w_sat[63:W];
  assign w_y_clamp_acc = {{(ACC_W-W){w_sat[W-1]}}, w_sat[W-1:0]};

  always_comb begin
    o_acc = w_sum;
    o_y   = w_sat[W-1:0];
    o_ovf = w_sat[64];
    if (i_bypass) begin
      o_acc = i_acc;
      o_y   = i_x;
      o_ovf = 1'b0;
    end else if (i_prime) begin
      o_acc = w_bias_acc <<< i_shift;
      o_y   = i_bias;
      o_ovf = 1'b0;
    end else if (w_sat[64]) begin
      // Reload from the clamped output so the state never runs past the output range.
      o_acc = w_y_clamp_acc <<< i_shift;
    end
  end

endmodule

// File: rtl/hpf_diff_iir.sv
// rtl/hpf_diff_iir.sv - multi-channel differential first-order HPF, one channel per cycle
module hpf_diff_iir
  import hpf_diff_iir_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int W         = 16,
  parameter int SHIFT_MAX = 10,
  parameter int ACC_W     = W + SHIFT_MAX + 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NCH*W-1:0]               in_p,
  input  logic [NCH*W-1:0]               in_n,
  input  logic [NCH*W-1:0]               bias_p,
  input  logic [NCH*W-1:0]               bias_n,
  input  logic [$clog2(SHIFT_MAX+1)-1:0] tau_shift,
  input  logic                           bypass,
  output logic                           out_valid,
  output logic [NCH*W-1:0]               out_p,
  output logic [NCH*W-1:0]               out_n,
  output logic [NCH-1:0]                 sat
);

  localparam int SW = $clog2(SHIFT_MAX + 1);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t                  r_state;
  logic [CW-1:0]           r_ch;
  logic [NCH*W-1:0]        r_in_p, r_in_n, r_bias_p, r_bias_n;
  logic [NCH*W-1:0]        r_xp_p, r_xp_n, r_stage_p, r_stage_n;
  logic [SW-1:0]           r_shift, r_prev_shift;
  logic                    r_bypass, r_prime, r_frame_prime;
  logic signed [ACC_W-1:0] r_acc_p [NCH];
  logic signed [ACC_W-1:0] r_acc_n [NCH];

  logic                    w_xfer, w_last;
  logic [SW-1:0]           w_shift;
  logic signed [W-1:0]     w_y_p, w_y_n;
  logic signed [ACC_W-1:0] w_acc_p_nxt, w_acc_n_nxt;
  logic                    w_ovf_p, w_ovf_n;
  logic [NCH*W-1:0]        w_stage_p_next, w_stage_n_next;

  assign w_xfer  = in_valid & in_ready;
  assign w_last  = (r_ch == CW'(NCH - 1));
  assign w_shift = SW'(clamp_shift(int'(tau_shift), SHIFT_MAX));

  hpf_leg_dp #(.W(W), .ACC_W(ACC_W), .SW(SW)) u_leg_p (
    .i_acc(r_acc_p[r_ch]), .i_x(r_in_p[r_ch*W +: W]), .i_x_prev(r_xp_p[r_ch*W +: W]),
    .i_bias(r_bias_p[r_ch*W +: W]), .i_shift(r_shift), .i_prime(r_frame_prime),
    .i_bypass(r_bypass), .o_acc(w_acc_p_nxt), .o_y(w_y_p), .o_ovf(w_ovf_p)
  );

  hpf_leg_dp #(.W(W), .ACC_W(ACC_W), .SW(SW)) u_leg_n (
    .i_acc(r_acc_n[r_ch]), .i_x(r_in_n[r_ch*W +: W]), .i_x_prev(r_xp_n[r_ch*W +: W]),
    .i_bias(r_bias_n[r_ch*W +: W]), .i_shift(r_shift), .i_prime(r_frame_prime),
    .i_bypass(r_bypass), .o_acc(w_acc_n_nxt), .o_y(w_y_n), .o_ovf(w_ovf_n)
  );

  // Staging merged with the current channel so the last channel reaches the outputs in DONE.
  always_comb begin
    w_stage_p_next = r_stage_p;
    w_stage_n_next = r_stage_n;
    w_stage_p_next[r_ch*W +: W] = w_y_p;
    w_stage_n_next[r_ch*W +: W] = w_y_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ch          <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_p         <= '0;
      out_n         <= '0;
      sat           <= '0;
      r_in_p        <= '0;
      r_in_n        <= '0;
      r_bias_p      <= '0;
      r_bias_n      <= '0;
      r_xp_p        <= '0;
      r_xp_n        <= '0;
      r_stage_p     <= '0;
      r_stage_n     <= '0;
      r_shift       <= '0;
      r_prev_shift  <= '0;
      r_bypass      <= 1'b0;
      r_prime       <= 1'b1;
      r_frame_prime <= 1'b1;
      for (int c = 0; c < NCH; c++) begin
        r_acc_p[c] <= '0;
        r_acc_n[c] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (w_xfer) begin
        r_in_p        <= in_p;
        r_in_n        <= in_n;
        r_bias_p      <= bias_p;
        r_bias_n      <= bias_n;
        r_shift       <= w_shift;
        r_bypass      <= bypass;
        // A changed time constant invalidates the scaled state, so that frame re-primes.
        r_frame_prime <= r_prime | (w_shift != r_prev_shift);
        r_prev_shift  <= w_shift;
        r_prime       <= bypass;
        r_ch          <= '0;
        r_state       <= CALC;
        in_ready      <= 1'b0;
      end
      case (r_state)
        CALC: begin
          r_acc_p[r_ch]       <= w_acc_p_nxt;
          r_acc_n[r_ch]       <= w_acc_n_nxt;
          r_xp_p[r_ch*W +: W] <= r_in_p[r_ch*W +: W];
          r_xp_n[r_ch*W +: W] <= r_in_n[r_ch*W +: W];
          sat[r_ch]           <= sat[r_ch] | w_ovf_p | w_ovf_n;
          r_stage_p           <= w_stage_p_next;
          r_stage_n           <= w_stage_n_next;
          if (w_last) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            out_p     <= w_stage_p_next;
            out_n     <= w_stage_n_next;
          end else begin
            r_ch <= r_ch + CW'(1);
          end
        end
        DONE: begin
          if (!w_xfer) r_state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hpf_diff_iir.sv
// tb/tb_hpf_diff_iir.sv - directed self-checking bench for hpf_diff_iir
module tb_hpf_diff_iir;
  localparam int NCH = 2;
  localparam int W = 16;
  localparam int SHIFT_MAX = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic bypass = 1'b0;
  logic in_ready, out_valid;
  logic [NCH*W-1:0] in_p = '0, in_n = '0, bias_p = '0, bias_n = '0;
  logic [3:0] tau_shift = 4'd4;
  logic [NCH*W-1:0] out_p, out_n;
  logic [NCH-1:0] sat;
  int checks = 0;
  int errors = 0;
  logic signed [W-1:0] op0, op1, on0, on1;

  assign op0 = out_p[0 +: W];
  assign op1 = out_p[W +: W];
  assign on0 = out_n[0 +: W];
  assign on1 = out_n[W +: W];

  always #5 clk = ~clk;

  hpf_diff_iir #(.NCH(NCH), .W(W), .SHIFT_MAX(SHIFT_MAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_n(in_n), .bias_p(bias_p), .bias_n(bias_n),
    .tau_shift(tau_shift), .bypass(bypass), .out_valid(out_valid),
    .out_p(out_p), .out_n(out_n), .sat(sat)
  );

  task automatic set_ch(input int c, input int ip, input int inn, input int bp, input int bn);
    in_p[c*W +: W]   = W'(ip);
    in_n[c*W +: W]   = W'(inn);
    bias_p[c*W +: W] = W'(bp);
    bias_n[c*W +: W] = W'(bn);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    bypass = 1'b0;
    in_p = '0; in_n = '0; bias_p = '0; bias_n = '0;
  endtask

  task automatic run_frame(output int lat);
    int n;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 50);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (out_p !== '0) begin errors++; $display("FAIL rst_out_p got %0h want 0", out_p); end
    checks++; if (out_n !== '0) begin errors++; $display("FAIL rst_out_n got %0h want 0", out_n); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (sat !== 2'b00) begin errors++; $display("FAIL rst_sat got %b want 00", sat); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_prime;
    int lat;
    do_reset;
    tau_shift = 4'd4;
    set_ch(0, 1000, 200, 100, 50);
    set_ch(1, -500, 3, -7, 0);
    run_frame(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL prime_latency got %0d want 3", lat); end
    checks++; if (op0 !== 100) begin errors++; $display("FAIL prime_p0 got %0d want 100", op0); end
    checks++; if (op1 !== -7) begin errors++; $display("FAIL prime_p1 got %0d want -7", op1); end
    checks++; if (on0 !== 50) begin errors++; $display("FAIL prime_n0 got %0d want 50", on0); end
    checks++; if (on1 !== 0) begin errors++; $display("FAIL prime_n1 got %0d want 0", on1); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prime_pulse_width got %b want 0", out_valid); end
    checks++; if (op0 !== 100) begin errors++; $display("FAIL prime_hold got %0d want 100", op0); end
  endtask

  task automatic test_decay;
    int lat;
    int exp_p[3] = '{1600, 1500, 1406};
    int exp_n[3] = '{-1600, -1500, -1407};
    do_reset;
    tau_shift = 4'd4;
    run_frame(lat);
    checks++; if (op0 !== 0) begin errors++; $display("FAIL decay_prime got %0d want 0", op0); end
    set_ch(0, 1600, 0, 0, 0);
    set_ch(1, 0, -1600, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_frame(lat);
      checks++; if (op0 !== exp_p[i]) begin errors++; $display("FAIL decay_p0[%0d] got %0d want %0d", i, op0, exp_p[i]); end
      checks++; if (on1 !== exp_n[i]) begin errors++; $display("FAIL decay_n1[%0d] got %0d want %0d", i, on1, exp_n[i]); end
    end
  endtask

  task automatic test_saturation;
    int lat;
    do_reset;
    tau_shift = 4'd4;
    set_ch(0, -32768, 0, 0, 0);
    set_ch(1, 0, 32767, 0, 0);
    run_frame(lat);
    checks++; if (sat !== 2'b00) begin errors++; $display("FAIL sat_prime got %b want 00", sat); end
    set_ch(0, 32767, 0, 0, 0);
    set_ch(1, 0, -32768, 0, 0);
    run_frame(lat);
    checks++; if (op0 !== 32767) begin errors++; $display("FAIL sat_p0_hi got %0d want 32767", op0); end
    checks++; if (on1 !== -32768) begin errors++; $display("FAIL sat_n1_lo got %0d want -32768", on1); end
    checks++; if (sat !== 2'b11) begin errors++; $display("FAIL sat_flags got %b want 11", sat); end
    run_frame(lat);
    checks++; if (op0 !== 30719) begin errors++; $display("FAIL sat_p0_reload got %0d want 30719", op0); end
    checks++; if (on1 !== -30720) begin errors++; $display("FAIL sat_n1_reload got %0d want -30720", on1); end
    checks++; if (sat !== 2'b11) begin errors++; $display("FAIL sat_sticky got %b want 11", sat); end
  endtask

  task automatic test_bypass_tau;
    int lat;
    do_reset;
    tau_shift = 4'd4;
    set_ch(0, 1000, 0, 100, 0);
    run_frame(lat);
    checks++; if (op0 !== 100) begin errors++; $display("FAIL byp_prime got %0d want 100", op0); end
    bypass = 1'b1;
    set_ch(0, 1234, -55, 100, 0);
    run_frame(lat);
    checks++; if (op0 !== 1234) begin errors++; $display("FAIL byp_p0 got %0d want 1234", op0); end
    checks++; if (on0 !== -55) begin errors++; $display("FAIL byp_n0 got %0d want -55", on0); end
    bypass = 1'b0;
    run_frame(lat);
    checks++; if (op0 !== 100) begin errors++; $display("FAIL byp_reprime got %0d want 100", op0); end
    set_ch(0, 1250, -55, 100, 0);
    run_frame(lat);
    checks++; if (op0 !== 116) begin errors++; $display("FAIL byp_after got %0d want 116", op0); end
    tau_shift = 4'd6;
    set_ch(0, 1300, -55, 100, 0);
    run_frame(lat);
    checks++; if (op0 !== 100) begin errors++; $display("FAIL tau_reprime got %0d want 100", op0); end
    set_ch(0, 1301, -55, 100, 0);
    run_frame(lat);
    checks++; if (op0 !== 101) begin errors++; $display("FAIL tau_after got %0d want 101", op0); end
  endtask

  task automatic test_tau_clamp;
    int lat;
    do_reset;
    tau_shift = 4'd15;
    run_frame(lat);
    set_ch(0, 1024, 0, 0, 0);
    run_frame(lat);
    checks++; if (op0 !== 1024) begin errors++; $display("FAIL clamp_step got %0d want 1024", op0); end
    run_frame(lat);
    checks++; if (op0 !== 1023) begin errors++; $display("FAIL clamp_decay got %0d want 1023", op0); end
    tau_shift = 4'd10;
    run_frame(lat);
    checks++; if (op0 !== 1022) begin errors++; $display("FAIL clamp_same_s got %0d want 1022", op0); end
  endtask

  task automatic test_back_to_back;
    int k, npulse, lx;
    int xfer_cyc[4];
    int pulse_cyc[4];
    logic will_xfer;
    do_reset;
    bypass = 1'b1;
    k = 0; npulse = 0; lx = -10; will_xfer = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (will_xfer) k++;
      if (cyc == lx + 1 || cyc == lx + 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_calc cyc %0d got %b want 0", cyc, in_ready); end
      end
      if (out_valid) begin
        if (npulse < 4) begin
          pulse_cyc[npulse] = cyc;
          checks++; if (op0 !== 11 * (npulse + 1)) begin errors++; $display("FAIL b2b_order[%0d] got %0d want %0d", npulse, op0, 11 * (npulse + 1)); end
          checks++; if (cyc - xfer_cyc[npulse] !== 3) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 3", npulse, cyc - xfer_cyc[npulse]); end
          if (npulse > 0) begin
            checks++; if (cyc - pulse_cyc[npulse-1] !== 3) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 3", npulse, cyc - pulse_cyc[npulse-1]); end
          end
        end
        npulse++;
      end
      if (k < 4) begin set_ch(0, 11 * (k + 1), 0, 0, 0); in_valid = 1'b1; end
      else in_valid = 1'b0;
      will_xfer = in_valid && in_ready;
      if (will_xfer) begin xfer_cyc[k] = cyc; lx = cyc; end
      @(negedge clk);
    end
    checks++; if (npulse !== 4) begin errors++; $display("FAIL b2b_pulse_count got %0d want 4", npulse); end
  endtask

  task automatic test_reset_midframe;
    int lat;
    do_reset;
    tau_shift = 4'd4;
    set_ch(0, 32767, 0, 0, 0);
    run_frame(lat);
    set_ch(0, -32768, 0, 0, 0);
    run_frame(lat);
    checks++; if (sat !== 2'b01) begin errors++; $display("FAIL mid_pre_sat got %b want 01", sat); end
    set_ch(0, 123, 45, 6, 7);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_p !== '0) begin errors++; $display("FAIL mid_out_p got %0h want 0", out_p); end
    checks++; if (out_n !== '0) begin errors++; $display("FAIL mid_out_n got %0h want 0", out_n); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    checks++; if (sat !== 2'b00) begin errors++; $display("FAIL mid_sat got %b want 00", sat); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    set_ch(0, 500, 0, 77, 0);
    run_frame(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mid_latency got %0d want 3", lat); end
    checks++; if (op0 !== 77) begin errors++; $display("FAIL mid_reprime got %0d want 77", op0); end
  endtask

  initial begin
    test_reset;
    test_prime;
    test_decay;
    test_saturation;
    test_bypass_tau;
    test_tau_clamp;
    test_back_to_back;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
